// File: rtl/snitch_icache_refill_ctrl.sv
// Miss/refill controller for the Snitch L1 instruction cache: serves hits, merges misses
// into an in-flight pending table, and fans refilled lines out to the cache and all waiting IDs.
module snitch_icache_refill_ctrl #(
   parameter int unsigned FETCH_AW      = 32,
   parameter int unsigned LINE_WIDTH    = 128,
   parameter int unsigned LINE_ALIGN    = 4,
   parameter int unsigned COUNT_ALIGN   = 5,
   parameter int unsigned SET_ALIGN     = 2,
   parameter int unsigned NR_IDS        = 4,
   parameter int unsigned PENDING_COUNT = 4,
   parameter int unsigned STARVE_MAX    = 3,
   parameter int unsigned EVICT_MODE    = 0,
   localparam int unsigned ID_W       = (NR_IDS > 1) ? $clog2(NR_IDS) : 1,
   localparam int unsigned PENDING_IW = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1,
   localparam int unsigned TAG_W      = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [FETCH_AW-1:0]   in_req_addr_i,
   input  logic [ID_W-1:0]       in_req_id_i,
   input  logic [SET_ALIGN-1:0]  in_req_set_i,
   input  logic                  in_req_hit_i,
   input  logic [LINE_WIDTH-1:0] in_req_data_i,
   input  logic                  in_req_error_i,
   input  logic                  in_req_valid_i,
   output logic                  in_req_ready_o,
   output logic [LINE_WIDTH-1:0] in_rsp_data_o,
   output logic                  in_rsp_error_o,
   output logic [NR_IDS-1:0]     in_rsp_id_o,
   output logic                  in_rsp_valid_o,
   input  logic                  in_rsp_ready_i,
   output logic [COUNT_ALIGN-1:0] write_addr_o,
   output logic [SET_ALIGN-1:0]  write_set_o,
   output logic [LINE_WIDTH-1:0] write_data_o,
   output logic [TAG_W-1:0]      write_tag_o,
   output logic                  write_error_o,
   output logic                  write_valid_o,
   input  logic                  write_ready_i,
   output logic [FETCH_AW-1:0]   out_req_addr_o,
   output logic [PENDING_IW-1:0] out_req_id_o,
   output logic                  out_req_valid_o,
   input  logic                  out_req_ready_i,
   input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
   input  logic                  out_rsp_error_i,
   input  logic [PENDING_IW-1:0] out_rsp_id_i,
   input  logic                  out_rsp_valid_i,
   output logic                  out_rsp_ready_o,
   input  logic                  flush_valid_i,
   output logic                  flush_ready_o
);

   // All handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid must not depend on ready, and a raised valid holds its payload until the transfer.

   localparam int unsigned DEPTH = 1 << PENDING_IW;
   localparam int unsigned SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [DEPTH-1:0]    r_valid;
   logic [FETCH_AW-1:0] r_addr [DEPTH];
   logic [NR_IDS-1:0]   r_mask [DEPTH];
   logic [NR_IDS-1:0]   r_mif;
   logic                r_rsp_served;
   logic                r_wr_served;
   logic                r_lock;
   logic                r_lock_rfl;
   logic [SW-1:0]       r_streak;

   logic [NR_IDS-1:0]     w_id_oh;
   logic                  w_match_found;
   logic [PENDING_IW-1:0] w_match_idx;
   logic                  w_free_found;
   logic [PENDING_IW-1:0] w_free_idx;
   logic                  w_mif_hit;
   logic                  w_req_ok;
   logic                  w_hit_req;
   logic                  w_merge;
   logic                  w_alloc_req;
   logic                  w_push;
   logic                  w_sel_rfl;
   logic [FETCH_AW-1:0]   w_pop_addr;
   logic [NR_IDS-1:0]     w_pop_mask;
   logic                  w_rsp_done;
   logic                  w_wr_done;
   logic                  w_complete;
   logic                  w_hit_xfer;
   logic [SET_ALIGN-1:0]  w_way;
   logic                  w_unused;

   always_comb begin
      w_id_oh = '0;
      for (int i = 0; i < int'(NR_IDS); i++) w_id_oh[i] = (in_req_id_i == ID_W'(i));
   end

   // An entry whose fetch response already went out cannot take new IDs; such a miss re-allocates.
   always_comb begin
      w_match_found = 1'b0;
      w_match_idx   = '0;
      w_free_found  = 1'b0;
      w_free_idx    = '0;
      for (int i = 0; i < int'(PENDING_COUNT); i++) begin
         if (!w_match_found && r_valid[i] && (r_addr[i] == in_req_addr_i) &&
             !(r_rsp_served && (out_rsp_id_i == PENDING_IW'(i)))) begin
            w_match_found = 1'b1;
            w_match_idx   = PENDING_IW'(i);
         end
         if (!w_free_found && !r_valid[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = PENDING_IW'(i);
         end
      end
   end

   assign w_mif_hit   = |(r_mif & w_id_oh);
   assign w_req_ok    = in_req_valid_i & ~w_mif_hit;
   assign w_hit_req   = w_req_ok & in_req_hit_i;
   assign w_merge     = w_req_ok & ~in_req_hit_i & w_match_found;
   assign w_alloc_req = w_req_ok & ~in_req_hit_i & ~w_match_found & ~flush_valid_i & w_free_found;
   assign w_push      = w_alloc_req & out_req_ready_i;

   assign w_sel_rfl = r_lock ? r_lock_rfl
                             : (out_rsp_valid_i & (~w_hit_req | (r_streak == STARVE_LIM)));

   // A merge into the entry being popped must reach the fetch response this cycle.
   assign w_pop_addr = r_addr[out_rsp_id_i];
   assign w_pop_mask = r_mask[out_rsp_id_i] |
                       ((w_merge && (w_match_idx == out_rsp_id_i)) ? w_id_oh : '0);

   assign in_rsp_valid_o = w_sel_rfl ? (out_rsp_valid_i & ~r_rsp_served) : w_hit_req;
   assign in_rsp_data_o  = w_sel_rfl ? out_rsp_data_i : in_req_data_i;
   assign in_rsp_error_o = w_sel_rfl & out_rsp_error_i;
   assign in_rsp_id_o    = w_sel_rfl ? w_pop_mask : w_id_oh;

   assign write_valid_o = w_sel_rfl & out_rsp_valid_i & ~r_wr_served;
   assign write_addr_o  = w_pop_addr[LINE_ALIGN +: COUNT_ALIGN];
   assign write_tag_o   = w_pop_addr[FETCH_AW-1 -: TAG_W];
   assign write_set_o   = w_way;
   assign write_data_o  = out_rsp_data_i;
   assign write_error_o = out_rsp_error_i;

   assign w_rsp_done      = r_rsp_served | (in_rsp_valid_o & in_rsp_ready_i);
   assign w_wr_done       = r_wr_served | (write_valid_o & write_ready_i);
   assign w_complete      = w_sel_rfl & out_rsp_valid_i & w_rsp_done & w_wr_done;
   assign out_rsp_ready_o = w_complete;
   assign w_hit_xfer      = w_hit_req & ~w_sel_rfl & in_rsp_ready_i;

   assign in_req_ready_o  = w_hit_xfer | w_merge | w_push;
   assign out_req_valid_o = w_alloc_req;
   assign out_req_addr_o  = in_req_addr_i;
   assign out_req_id_o    = w_free_idx;

   assign flush_ready_o = ~|r_valid & ~|r_mif & ~r_rsp_served & ~r_wr_served &
                          ~(r_lock & r_lock_rfl);

   assign w_unused = ^{in_req_set_i, in_req_error_i, w_pop_addr[LINE_ALIGN-1:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_addr[i] <= '0;
            r_mask[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_push && (w_free_idx == PENDING_IW'(i))) begin
               r_valid[i] <= 1'b1;
               r_addr[i]  <= in_req_addr_i;
               r_mask[i]  <= w_id_oh;
            end else if (w_merge && (w_match_idx == PENDING_IW'(i))) begin
               r_mask[i] <= r_mask[i] | w_id_oh;
            end
            if (w_complete && (out_rsp_id_i == PENDING_IW'(i))) r_valid[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mif        <= '0;
         r_rsp_served <= 1'b0;
         r_wr_served  <= 1'b0;
         r_lock       <= 1'b0;
         r_lock_rfl   <= 1'b0;
         r_streak     <= '0;
      end else begin
         r_mif <= (r_mif | ((w_push | w_merge) ? w_id_oh : '0)) &
                  ~((in_rsp_valid_o & in_rsp_ready_i) ? in_rsp_id_o : '0);
         if (w_complete) begin
            r_rsp_served <= 1'b0;
            r_wr_served  <= 1'b0;
         end else if (w_sel_rfl) begin
            r_rsp_served <= w_rsp_done;
            r_wr_served  <= w_wr_done;
         end
         r_lock     <= w_sel_rfl ? (out_rsp_valid_i & ~w_complete) : (w_hit_req & ~in_rsp_ready_i);
         r_lock_rfl <= w_sel_rfl;
         if (!out_rsp_valid_i || w_complete) r_streak <= '0;
         else if (w_hit_xfer && (r_streak != STARVE_LIM)) r_streak <= r_streak + SW'(1);
      end
   end

   if (EVICT_MODE == 0) begin : g_lfsr
      logic [15:0] r_lfsr;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) r_lfsr <= 16'h0001;
         else if (w_complete) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      end
      assign w_way = r_lfsr[SET_ALIGN-1:0];
   end else begin : g_rr
      logic [SET_ALIGN-1:0] r_way;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) r_way <= '0;
         else if (w_complete) r_way <= r_way + SET_ALIGN'(1);
      end
      assign w_way = r_way;
   end

endmodule

// File: tb/tb_snitch_icache_refill_ctrl.sv
// Directed bench for snitch_icache_refill_ctrl: hits, merges, table-full stall, split sink
// acceptance, flush drain, starvation bound and round-robin eviction order.
module tb_snitch_icache_refill_ctrl;

   localparam int unsigned FETCH_AW = 32;
   localparam int unsigned LW       = 128;
   localparam int unsigned SA       = 2;
   localparam int unsigned NID      = 4;
   localparam int unsigned PIW      = 1;
   localparam int unsigned TAG_W    = FETCH_AW - 4 - 5;

   logic              clk_i;
   logic              rst_ni;
   logic [FETCH_AW-1:0] in_req_addr_i;
   logic [1:0]        in_req_id_i;
   logic [SA-1:0]     in_req_set_i;
   logic              in_req_hit_i;
   logic [LW-1:0]     in_req_data_i;
   logic              in_req_error_i;
   logic              in_req_valid_i;
   logic              in_req_ready_o;
   logic [LW-1:0]     in_rsp_data_o;
   logic              in_rsp_error_o;
   logic [NID-1:0]    in_rsp_id_o;
   logic              in_rsp_valid_o;
   logic              in_rsp_ready_i;
   logic [4:0]        write_addr_o;
   logic [SA-1:0]     write_set_o;
   logic [LW-1:0]     write_data_o;
   logic [TAG_W-1:0]  write_tag_o;
   logic              write_error_o;
   logic              write_valid_o;
   logic              write_ready_i;
   logic [FETCH_AW-1:0] out_req_addr_o;
   logic [PIW-1:0]    out_req_id_o;
   logic              out_req_valid_o;
   logic              out_req_ready_i;
   logic [LW-1:0]     out_rsp_data_i;
   logic              out_rsp_error_i;
   logic [PIW-1:0]    out_rsp_id_i;
   logic              out_rsp_valid_i;
   logic              out_rsp_ready_o;
   logic              flush_valid_i;
   logic              flush_ready_o;

   logic [NID+LW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   snitch_icache_refill_ctrl #(
      .FETCH_AW(FETCH_AW), .LINE_WIDTH(LW), .LINE_ALIGN(4), .COUNT_ALIGN(5), .SET_ALIGN(SA),
      .NR_IDS(NID), .PENDING_COUNT(2), .STARVE_MAX(3), .EVICT_MODE(1)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_req_addr_i(in_req_addr_i), .in_req_id_i(in_req_id_i), .in_req_set_i(in_req_set_i),
      .in_req_hit_i(in_req_hit_i), .in_req_data_i(in_req_data_i), .in_req_error_i(in_req_error_i),
      .in_req_valid_i(in_req_valid_i), .in_req_ready_o(in_req_ready_o),
      .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o), .in_rsp_id_o(in_rsp_id_o),
      .in_rsp_valid_o(in_rsp_valid_o), .in_rsp_ready_i(in_rsp_ready_i),
      .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
      .write_tag_o(write_tag_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
      .write_ready_i(write_ready_i),
      .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o),
      .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
      .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i),
      .out_rsp_id_i(out_rsp_id_i), .out_rsp_valid_i(out_rsp_valid_i),
      .out_rsp_ready_o(out_rsp_ready_o),
      .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [NID+LW-1:0] obs, input logic [NID+LW-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [LW-1:0] pat(input int k);
      pat = {4{32'hC0DE_0000 + 32'(k)}};
   endfunction

   // driver tasks
   task automatic idle();
      in_req_valid_i  = 1'b0;
      in_req_hit_i    = 1'b0;
      in_req_addr_i   = '0;
      in_req_id_i     = '0;
      in_req_set_i    = '0;
      in_req_data_i   = '0;
      in_req_error_i  = 1'b0;
      out_rsp_valid_i = 1'b0;
      out_rsp_id_i    = '0;
      out_rsp_data_i  = '0;
      out_rsp_error_i = 1'b0;
      in_rsp_ready_i  = 1'b1;
      write_ready_i   = 1'b1;
      out_req_ready_i = 1'b1;
      flush_valid_i   = 1'b0;
   endtask

   task automatic drive_miss(input int id, input logic [FETCH_AW-1:0] addr);
      in_req_valid_i = 1'b1;
      in_req_hit_i   = 1'b0;
      in_req_id_i    = 2'(id);
      in_req_addr_i  = addr;
      in_req_data_i  = '0;
   endtask

   task automatic drive_hit(input int id, input logic [FETCH_AW-1:0] addr, input logic [LW-1:0] data);
      in_req_valid_i = 1'b1;
      in_req_hit_i   = 1'b1;
      in_req_id_i    = 2'(id);
      in_req_addr_i  = addr;
      in_req_data_i  = data;
   endtask

   task automatic drive_rsp(input int pid, input logic [LW-1:0] data);
      out_rsp_valid_i = 1'b1;
      out_rsp_id_i    = PIW'(pid);
      out_rsp_data_i  = data;
      out_rsp_error_i = 1'b0;
   endtask

   // scoreboard: every fetch-response transfer must match the head of exp_q
   always @(negedge clk_i) begin
      #2;
      if (rst_ni && in_rsp_valid_o && in_rsp_ready_i) begin
         chk("rsp_expected", (exp_q.size() != 0), 1'b1);
         if (exp_q.size() != 0) chk("rsp_id_data", {in_rsp_id_o, in_rsp_data_o}, exp_q.pop_front());
      end
   end

   initial begin
      rst_ni = 1'b0;
      idle();
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_in_rsp_valid", in_rsp_valid_o, 1'b0);
      chk("rst_write_valid", write_valid_o, 1'b0);
      chk("rst_out_req_valid", out_req_valid_o, 1'b0);
      chk("rst_out_rsp_ready", out_rsp_ready_o, 1'b0);
      chk("rst_flush_ready", flush_ready_o, 1'b1);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // hit path is combinational
      @(negedge clk_i);
      drive_hit(2, 32'h200, pat(1));
      exp_q.push_back({4'b0100, pat(1)});
      #1;
      chk("hit_valid", in_rsp_valid_o, 1'b1);
      chk("hit_id", in_rsp_id_o, 4'b0100);
      chk("hit_data", in_rsp_data_o, pat(1));
      chk("hit_no_out_req", out_req_valid_o, 1'b0);
      chk("hit_ready", in_req_ready_o, 1'b1);

      // miss then merge: one refill request, one write, response to both IDs
      @(negedge clk_i);
      drive_miss(0, 32'h5A30);
      #1;
      chk("miss_out_req_valid", out_req_valid_o, 1'b1);
      chk("miss_out_req_id", out_req_id_o, 1'b0);
      chk("miss_out_req_addr", out_req_addr_o, 32'h5A30);
      chk("miss_ready", in_req_ready_o, 1'b1);
      @(negedge clk_i);
      drive_miss(1, 32'h5A30);
      #1;
      chk("merge_no_out_req", out_req_valid_o, 1'b0);
      chk("merge_ready", in_req_ready_o, 1'b1);
      @(negedge clk_i);
      in_req_valid_i = 1'b0;
      #1;
      chk("pending_flush_ready", flush_ready_o, 1'b0);
      @(negedge clk_i);
      drive_rsp(0, pat(2));
      exp_q.push_back({4'b0011, pat(2)});
      #1;
      chk("merge_write_valid", write_valid_o, 1'b1);
      chk("merge_write_addr", write_addr_o, 5'h03);
      chk("merge_write_tag", write_tag_o, 23'h2D);
      chk("merge_write_set", write_set_o, 2'd0);
      chk("merge_rsp_id", in_rsp_id_o, 4'b0011);
      chk("merge_out_rsp_ready", out_rsp_ready_o, 1'b1);
      @(negedge clk_i);
      out_rsp_valid_i = 1'b0;
      #1;
      chk("drained_flush_ready", flush_ready_o, 1'b1);

      // table full with two entries
      @(negedge clk_i);
      drive_miss(0, 32'h1000);
      out_req_ready_i = 1'b0;
      #1;
      chk("miss_comb_ready_lo", in_req_ready_o, 1'b0);
      chk("miss_comb_out_req_valid", out_req_valid_o, 1'b1);
      out_req_ready_i = 1'b1;
      #1;
      chk("miss_comb_ready_hi", in_req_ready_o, 1'b1);
      chk("full_alloc0_id", out_req_id_o, 1'b0);
      @(negedge clk_i);
      drive_miss(1, 32'h2000);
      #1;
      chk("full_alloc1_id", out_req_id_o, 1'b1);
      @(negedge clk_i);
      drive_miss(2, 32'h3000);
      #1;
      chk("full_stall_ready", in_req_ready_o, 1'b0);
      chk("full_no_out_req", out_req_valid_o, 1'b0);
      @(negedge clk_i);
      drive_rsp(0, pat(3));
      exp_q.push_back({4'b0001, pat(3)});
      #1;
      chk("full_still_stalled", in_req_ready_o, 1'b0);
      chk("full_out_rsp_ready", out_rsp_ready_o, 1'b1);
      chk("full_write_set", write_set_o, 2'd1);
      @(negedge clk_i);
      out_rsp_valid_i = 1'b0;
      #1;
      chk("full_realloc_valid", out_req_valid_o, 1'b1);
      chk("full_realloc_id", out_req_id_o, 1'b0);
      chk("full_realloc_ready", in_req_ready_o, 1'b1);

      // write sink stalls two cycles, fetch response accepted at once
      @(negedge clk_i);
      in_req_valid_i = 1'b0;
      write_ready_i  = 1'b0;
      drive_rsp(1, pat(4));
      exp_q.push_back({4'b0010, pat(4)});
      #1;
      chk("wstall_c0_rsp_valid", in_rsp_valid_o, 1'b1);
      chk("wstall_c0_write_valid", write_valid_o, 1'b1);
      chk("wstall_c0_out_rsp_ready", out_rsp_ready_o, 1'b0);
      @(negedge clk_i);
      #1;
      chk("wstall_c1_rsp_dropped", in_rsp_valid_o, 1'b0);
      chk("wstall_c1_write_valid", write_valid_o, 1'b1);
      chk("wstall_c1_out_rsp_ready", out_rsp_ready_o, 1'b0);
      @(negedge clk_i);
      write_ready_i = 1'b1;
      #1;
      chk("wstall_c2_write_valid", write_valid_o, 1'b1);
      chk("wstall_c2_out_rsp_ready", out_rsp_ready_o, 1'b1);
      chk("wstall_c2_write_set", write_set_o, 2'd2);
      @(negedge clk_i);
      out_rsp_valid_i = 1'b0;
      #1;
      chk("wstall_done_write_valid", write_valid_o, 1'b0);

      // flush drain with entry 0 (id2) still pending
      @(negedge clk_i);
      flush_valid_i = 1'b1;
      drive_miss(3, 32'h4000);
      #1;
      chk("flush_stall_ready", in_req_ready_o, 1'b0);
      chk("flush_no_out_req", out_req_valid_o, 1'b0);
      chk("flush_not_ready", flush_ready_o, 1'b0);
      @(negedge clk_i);
      in_req_valid_i = 1'b0;
      drive_rsp(0, pat(5));
      exp_q.push_back({4'b0100, pat(5)});
      #1;
      chk("flush_write_set", write_set_o, 2'd3);
      chk("flush_out_rsp_ready", out_rsp_ready_o, 1'b1);
      chk("flush_busy_last_rsp", flush_ready_o, 1'b0);
      @(negedge clk_i);
      out_rsp_valid_i = 1'b0;
      #1;
      chk("flush_ready_after", flush_ready_o, 1'b1);
      flush_valid_i = 1'b0;

      // starvation bound: three hits, then the waiting refill wins
      @(negedge clk_i);
      drive_miss(0, 32'h6000);
      #1;
      chk("starve_alloc0_id", out_req_id_o, 1'b0);
      @(negedge clk_i);
      drive_miss(2, 32'h8000);
      #1;
      chk("starve_alloc1_id", out_req_id_o, 1'b1);
      @(negedge clk_i);
      drive_rsp(0, pat(6));
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk_i);
         drive_hit(1, 32'h7000, pat(10 + k));
         exp_q.push_back({4'b0010, pat(10 + k)});
         #1;
         chk($sformatf("starve_hit%0d_id", k), in_rsp_id_o, 4'b0010);
         chk($sformatf("starve_hit%0d_no_write", k), write_valid_o, 1'b0);
      end
      @(negedge clk_i);
      drive_hit(1, 32'h7000, pat(13));
      exp_q.push_back({4'b0001, pat(6)});
      #1;
      chk("starve_rfl_write_valid", write_valid_o, 1'b1);
      chk("starve_rfl_rsp_id", in_rsp_id_o, 4'b0001);
      chk("starve_rfl_out_rsp_ready", out_rsp_ready_o, 1'b1);
      chk("starve_rfl_hit_stalled", in_req_ready_o, 1'b0);
      chk("starve_rfl_write_set", write_set_o, 2'd0);
      @(negedge clk_i);
      drive_rsp(1, pat(7));
      exp_q.push_back({4'b0010, pat(13)});
      #1;
      chk("streak_cleared_hit_wins", in_rsp_id_o, 4'b0010);
      chk("streak_cleared_no_write", write_valid_o, 1'b0);
      @(negedge clk_i);
      in_req_valid_i = 1'b0;
      exp_q.push_back({4'b0100, pat(7)});
      #1;
      chk("last_rfl_write_valid", write_valid_o, 1'b1);
      chk("last_rfl_write_set", write_set_o, 2'd1);
      chk("last_rfl_out_rsp_ready", out_rsp_ready_o, 1'b1);
      @(negedge clk_i);
      idle();
      #1;
      chk("end_flush_ready", flush_ready_o, 1'b1);

      @(negedge clk_i);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/snitch_icache_refill_ctrl.md
# snitch_icache_refill_ctrl

Parametrised miss/refill controller for the Snitch L1 instruction cache, sitting between the lookup stage and the refill port. It serves hits, merges misses to lines already in flight, and allocates new refills in a configurable pending table. It writes refilled lines into a way chosen by LFSR or round-robin, and returns data to all waiting fetch IDs. Over the previous handler it adds:
- bounded hit-over-refill starvation;
- a selectable eviction policy;
- a flush-drain handshake;
- free parametrisation of ID count and pending depth.

## Interface
Parameters:
- FETCH_AW, 32, fetch address width (line-aligned addresses)
- LINE_WIDTH, 128, cache line data width
- LINE_ALIGN, 4, log2 line size in bytes
- COUNT_ALIGN, 5, log2 lines per way (index width)
- SET_ALIGN, 2, log2 ways; must be ≥1
- NR_IDS, 4, number of fetch IDs; response id is a one-hot/multi-hot mask of NR_IDS bits
- PENDING_COUNT, 4, refill table depth, 1..16; PENDING_IW = max(1, clog2(PENDING_COUNT))
- STARVE_MAX, 3, max consecutive hit transfers while a refill response waits; 0 = refill always wins
- EVICT_MODE, 0, 0 = LFSR, 1 = round-robin way counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- in_req_{addr,id,set,hit,data,error,valid}_i / in_req_ready_o  in/out  FETCH_AW, clog2(NR_IDS), SET_ALIGN, 1, LINE_WIDTH, 1, 1 / 1  lookup result
- in_rsp_{data,error,id,valid}_o / in_rsp_ready_i  out/in  LINE_WIDTH, 1, NR_IDS, 1 / 1  fetch response
- write_{addr,set,data,tag,error,valid}_o / write_ready_i  out/in  COUNT_ALIGN, SET_ALIGN, LINE_WIDTH, FETCH_AW-LINE_ALIGN-COUNT_ALIGN, 1, 1 / 1  cache fill
- out_req_{addr,id,valid}_o / out_req_ready_i  out/in  FETCH_AW, PENDING_IW, 1 / 1  refill request
- out_rsp_{data,error,id,valid}_i / out_rsp_ready_o  in/out  LINE_WIDTH, 1, PENDING_IW, 1 / 1  refill response
- flush_valid_i / flush_ready_o  in/out  1 / 1  drain request / drained

## Operation
- Pending table: PENDING_COUNT entries {valid, addr, idmask}, all valid=0 at reset.
  - Free entry = lowest-index invalid entry.
  - Match = lowest-index valid entry whose addr equals in_req_addr_i.
- Push on the same cycle as a pop of the same index: the pop sees the merged addr/idmask, and the entry ends invalid.
- miss_in_flight[NR_IDS] register:
  - set by push idmask;
  - cleared by (in_rsp_valid_o & in_rsp_ready_i) & in_rsp_id_o.
- Request priority for valid in_req, first match wins:
  - (1) miss_in_flight[id]: stall, ready=0.
  - (2) hit: present to the arbiter; ready = hit accepted.
  - (3) pending match: merge 1<<id into the entry; ready=1.
  - (4) flush_valid_i: stall, no new allocation.
  - (5) free entry: out_req_valid_o=1, out_req_id_o=free index; ready=push=out_req_ready_i; push initialises the idmask.
  - (6) table full: stall.
- Arbiter (hit vs refill response):
  - While a grant is outstanding (valid, not yet accepted), it is locked.
  - When unlocked, refill wins if out_rsp_valid_i and (no hit, or streak == STARVE_MAX); otherwise a hit wins.
- streak counter (width clog2(STARVE_MAX+1), reset 0):
  - +1 per hit transfer while out_rsp_valid_i=1;
  - cleared on refill transfer or when out_rsp_valid_i=0;
  - saturates at STARVE_MAX.
- Refill path:
  - write_valid_o and in_rsp_valid_o are raised together. Each side is accepted independently and latched in a served flag.
  - Completion = both served. On completion: out_rsp_ready_o=1, pop the entry, advance eviction, clear the flags.
  - Hit responses drive error=0 and id=1<<in_req_id_i.
- Write fields: addr = pop_addr[LINE_ALIGN+:COUNT_ALIGN], tag = upper bits, set = evict way.
- Eviction:
  - EVICT_MODE 0: LFSR advanced per completion.
  - EVICT_MODE 1: counter, reset 0, +1 mod 2^SET_ALIGN per completion.
- flush_ready_o = no valid table entry & miss_in_flight == 0 & no refill in progress. It is combinational and does not depend on flush_valid_i.

## Timing
- Reset values: in_rsp_valid_o, write_valid_o, out_req_valid_o, out_rsp_ready_o (no response) = 0; flush_ready_o = 1; streak = 0; served flags = 0.
- Combinational paths:
  - hit: in_req_valid_i to in_rsp_valid_o, 0 cycles;
  - miss: out_req_ready_i to in_req_ready_o, 0 cycles.
- Refill response to in_rsp: 0 cycles when both sinks are ready. Otherwise valid holds until each sink is served; already-served outputs deassert the next cycle.
- Merged IDs get their response in the same transfer as the allocating ID.
- Asynchronous reset mid-refill clears the table, served flags, and the lock. Outstanding refill responses after reset are the integrator's responsibility.

## Test plan
- Hit, in_rsp_ready_i=1, id=2 → in_rsp_id_o=4'b0100 and data equal to in_req_data_i in the same cycle; no out_req.
- Miss on addr 0x100 from id0, then id1 to 0x100 → a single out_req (id 0); the response carries in_rsp_id_o=4'b0011 and writes tag/index of 0x100 once.
- PENDING_COUNT=2, three misses to distinct lines → the third stalls until the first response completes, then allocates entry 0.
- STARVE_MAX=3, continuous hits plus a waiting refill response → exactly 3 hits, then the refill transfers; streak returns to 0.
- write_ready_i=0 for 2 cycles, in_rsp accepted in cycle 0 → in_rsp_valid_o drops after cycle 0; write completes in cycle 2 with out_rsp_ready_o=1.
- EVICT_MODE=1, SET_ALIGN=2, five refills → write_set_o = 0, 1, 2, 3, 0. Assert flush_valid_i with 1 pending → new misses stall; flush_ready_o rises the cycle after the last response.
